// File: rtl/pcie_cfg_pkg.sv
// Shared PCIe configuration constants and the memory request record used by
// the memory request arbiter.
package pcie_cfg_pkg;

  localparam int CFG_PCIE_DMAADDR_WIDTH = 32;

  typedef struct packed {
    logic                              write;
    logic [9:0]                        bytes;
    logic [CFG_PCIE_DMAADDR_WIDTH-1:0] addr;
    logic [7:0]                        strob;
    logic [63:0]                       data;
    logic                              last;
  } pcie_mem_req_type;

  localparam pcie_mem_req_type pcie_mem_req_none = '0;

endpackage

// File: rtl/pcie_arb_id_fifo.sv
// In-order 1-bit requester-ID FIFO; head names the owner of the oldest
// outstanding memory beat.
module pcie_arb_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  logic i_push_id,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output logic o_head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_id;
  end

endmodule

// File: rtl/pcie_mem_req_arbiter.sv
// Round-robin, burst-locked arbiter between the PCIe IO RX engine (0) and the
// DMA engine (1) onto one memory request port, with in-order response routing.
module pcie_mem_req_arbiter
  import pcie_cfg_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_WIDTH      = CFG_PCIE_DMAADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic                  i_req0_write,
  input  logic [9:0]            i_req0_bytes,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [7:0]            i_req0_strob,
  input  logic [63:0]           i_req0_data,
  input  logic                  i_req0_last,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic                  i_req1_write,
  input  logic [9:0]            i_req1_bytes,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [7:0]            i_req1_strob,
  input  logic [63:0]           i_req1_data,
  input  logic                  i_req1_last,
  output logic                  o_resp0_valid,
  output logic [63:0]           o_resp0_data,
  output logic                  o_resp1_valid,
  output logic [63:0]           o_resp1_data,
  output logic                  o_mem_valid,
  input  logic                  i_mem_ready,
  output logic                  o_mem_write,
  output logic [9:0]            o_mem_bytes,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [7:0]            o_mem_strob,
  output logic [63:0]           o_mem_data,
  output logic                  o_mem_last,
  input  logic                  i_mem_resp_valid,
  input  logic [63:0]           i_mem_resp_data,
  output logic [1:0]            o_grant,
  output logic                  o_err_resp
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY0 = 2'd1,
    S_BUSY1 = 2'd2
  } state_e;

  state_e           r_state, w_state_nxt;
  logic             r_rr_prio, w_rr_prio_nxt;
  logic             r_err;
  logic             w_full, w_empty, w_head;
  logic             w_push, w_push_id, w_pop;
  pcie_mem_req_type w_req0, w_req1, w_sel;

  always_comb begin
    w_req0 = '{write: i_req0_write, bytes: i_req0_bytes,
               addr: CFG_PCIE_DMAADDR_WIDTH'(i_req0_addr), strob: i_req0_strob,
               data: i_req0_data, last: i_req0_last};
    w_req1 = '{write: i_req1_write, bytes: i_req1_bytes,
               addr: CFG_PCIE_DMAADDR_WIDTH'(i_req1_addr), strob: i_req1_strob,
               data: i_req1_data, last: i_req1_last};
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rr_prio_nxt = r_rr_prio;
    w_sel         = pcie_mem_req_none;
    w_push_id     = 1'b0;
    o_mem_valid   = 1'b0;
    o_req0_ready  = 1'b0;
    o_req1_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req0_valid && i_req1_valid) w_state_nxt = r_rr_prio ? S_BUSY1 : S_BUSY0;
        else if (i_req0_valid)            w_state_nxt = S_BUSY0;
        else if (i_req1_valid)            w_state_nxt = S_BUSY1;
      end
      S_BUSY0: begin
        w_sel        = w_req0;
        o_mem_valid  = i_req0_valid & ~w_full;
        o_req0_ready = i_mem_ready & ~w_full;
        if (o_mem_valid && i_mem_ready && i_req0_last) begin
          w_state_nxt   = S_IDLE;
          w_rr_prio_nxt = 1'b1;
        end
      end
      S_BUSY1: begin
        w_sel        = w_req1;
        w_push_id    = 1'b1;
        o_mem_valid  = i_req1_valid & ~w_full;
        o_req1_ready = i_mem_ready & ~w_full;
        if (o_mem_valid && i_mem_ready && i_req1_last) begin
          w_state_nxt   = S_IDLE;
          w_rr_prio_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_rr_prio <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_prio <= w_rr_prio_nxt;
      r_err     <= r_err | (i_mem_resp_valid & w_empty);
    end
  end

  assign w_push = o_mem_valid & i_mem_ready;
  assign w_pop  = i_mem_resp_valid & ~w_empty;

  pcie_arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (w_push),
    .i_push_id (w_push_id),
    .i_pop     (w_pop),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_head    (w_head)
  );

  assign o_mem_write   = w_sel.write;
  assign o_mem_bytes   = w_sel.bytes;
  assign o_mem_addr    = w_sel.addr[ADDR_WIDTH-1:0];
  assign o_mem_strob   = w_sel.strob;
  assign o_mem_data    = w_sel.data;
  assign o_mem_last    = w_sel.last;

  assign o_resp0_valid = w_pop & ~w_head;
  assign o_resp1_valid = w_pop & w_head;
  assign o_resp0_data  = i_mem_resp_data;
  assign o_resp1_data  = i_mem_resp_data;

  assign o_grant       = {r_state == S_BUSY1, r_state == S_BUSY0};
  assign o_err_resp    = r_err;

endmodule

// File: tb/tb_pcie_mem_req_arbiter.sv
// Directed bench for pcie_mem_req_arbiter: inputs change on the falling edge,
// outputs are compared 1ns later against hand-derived values.
module tb_pcie_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid, req0_ready, req0_write, req0_last;
  logic [9:0]  req0_bytes;
  logic [31:0] req0_addr;
  logic [7:0]  req0_strob;
  logic [63:0] req0_data;
  logic        req1_valid, req1_ready, req1_write, req1_last;
  logic [9:0]  req1_bytes;
  logic [31:0] req1_addr;
  logic [7:0]  req1_strob;
  logic [63:0] req1_data;
  logic        resp0_valid, resp1_valid;
  logic [63:0] resp0_data, resp1_data;
  logic        mem_valid, mem_ready, mem_write, mem_last;
  logic [9:0]  mem_bytes;
  logic [31:0] mem_addr;
  logic [7:0]  mem_strob;
  logic [63:0] mem_data;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic [1:0]  grant;
  logic        err_resp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pcie_mem_req_arbiter #(.MAX_OUTSTANDING(4), .ADDR_WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_write(req0_write),
    .i_req0_bytes(req0_bytes), .i_req0_addr(req0_addr), .i_req0_strob(req0_strob),
    .i_req0_data(req0_data), .i_req0_last(req0_last),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_write(req1_write),
    .i_req1_bytes(req1_bytes), .i_req1_addr(req1_addr), .i_req1_strob(req1_strob),
    .i_req1_data(req1_data), .i_req1_last(req1_last),
    .o_resp0_valid(resp0_valid), .o_resp0_data(resp0_data),
    .o_resp1_valid(resp1_valid), .o_resp1_data(resp1_data),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_write(mem_write),
    .o_mem_bytes(mem_bytes), .o_mem_addr(mem_addr), .o_mem_strob(mem_strob),
    .o_mem_data(mem_data), .o_mem_last(mem_last),
    .i_mem_resp_valid(mem_resp_valid), .i_mem_resp_data(mem_resp_data),
    .o_grant(grant), .o_err_resp(err_resp)
  );

  task automatic idle_inputs();
    req0_valid = 0; req0_write = 0; req0_bytes = '0; req0_addr = '0;
    req0_strob = '0; req0_data = '0; req0_last = 0;
    req1_valid = 0; req1_write = 0; req1_bytes = '0; req1_addr = '0;
    req1_strob = '0; req1_data = '0; req1_last = 0;
    mem_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  // Leaves the bench on a falling edge with the DUT freshly reset.
  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
    checks++; if ({resp0_valid, resp1_valid} !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got=%b exp=00", {resp0_valid, resp1_valid}); end
    checks++; if (err_resp !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_resp); end
    checks++; if ({mem_addr, mem_data, mem_last} !== '0) begin errors++; $display("FAIL reset_mem_fields addr=%h data=%h exp=0", mem_addr, mem_data); end
    rst = 0;
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1; req0_addr = 32'h0800_0010; req0_bytes = 10'd4; req0_last = 1; mem_ready = 1;
    #1;
    checks++; if (grant !== 2'b00 || mem_valid !== 1'b0 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL single_idle grant=%b mem_valid=%b ready0=%b exp 00/0/0", grant, mem_valid, req0_ready); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant got=%b exp=01", grant); end
    checks++; if (mem_valid !== 1'b1 || req0_ready !== 1'b1) begin errors++; $display("FAIL single_handshake mem_valid=%b ready0=%b exp=1/1", mem_valid, req0_ready); end
    checks++; if (mem_addr !== 32'h0800_0010 || mem_bytes !== 10'd4 || mem_write !== 1'b0) begin
      errors++; $display("FAIL single_fields addr=%h bytes=%0d wr=%b exp=08000010/4/0", mem_addr, mem_bytes, mem_write); end
    @(negedge clk);
    req0_valid = 0; mem_resp_valid = 1; mem_resp_data = 64'hDEAD_BEEF;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_release got=%b exp=00", grant); end
    checks++; if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0) begin errors++; $display("FAIL single_route r0=%b r1=%b exp=1/0", resp0_valid, resp1_valid); end
    checks++; if (resp0_data !== 64'hDEAD_BEEF) begin errors++; $display("FAIL single_data got=%h exp=deadbeef", resp0_data); end
    @(negedge clk);
    mem_resp_valid = 0;
    #1;
    checks++; if (err_resp !== 1'b0) begin errors++; $display("FAIL single_no_err got=%b exp=0", err_resp); end
  endtask

  task automatic test_contention();
    logic [1:0] eg [9];
    int b0, b1;
    logic pacc, pid;
    eg = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0};
    b0 = 0; b1 = 0; pacc = 0; pid = 0;
    do_reset();
    mem_ready = 1;
    for (int c = 0; c < 9; c++) begin
      req0_valid = (b0 < 3); req0_last = (b0 == 2); req0_addr = 32'h100 + 32'(b0 * 8);
      req1_valid = (b1 < 3); req1_last = (b1 == 2); req1_addr = 32'h200 + 32'(b1 * 8);
      mem_resp_valid = pacc;
      #1;
      checks++; if (grant !== eg[c]) begin errors++; $display("FAIL contend_grant c=%0d got=%b exp=%b", c, grant, eg[c]); end
      checks++; if ({req1_ready, req0_ready} !== eg[c]) begin errors++; $display("FAIL contend_ready c=%0d got=%b exp=%b", c, {req1_ready, req0_ready}, eg[c]); end
      if (eg[c] == 2'd1) begin
        checks++; if (mem_addr !== 32'h100 + 32'(b0 * 8)) begin errors++; $display("FAIL contend_addr0 c=%0d got=%h", c, mem_addr); end
      end else if (eg[c] == 2'd2) begin
        checks++; if (mem_addr !== 32'h200 + 32'(b1 * 8)) begin errors++; $display("FAIL contend_addr1 c=%0d got=%h", c, mem_addr); end
      end
      if (pacc) begin
        checks++; if ({resp1_valid, resp0_valid} !== (pid ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL contend_route c=%0d got=%b exp_id=%0d", c, {resp1_valid, resp0_valid}, pid); end
      end
      pacc = (eg[c] != 2'd0); pid = eg[c][1];
      if (eg[c][0]) b0++;
      if (eg[c][1]) b1++;
      @(negedge clk);
    end
    req0_valid = 1; req0_last = 1; req1_valid = 1; req1_last = 1; mem_resp_valid = 0;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_idle got=%b exp=00", grant); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_winner got=%b exp=01", grant); end
  endtask

  task automatic test_lock_stall();
    int b1;
    b1 = 0;
    do_reset();
    req1_valid = 1; mem_ready = 1;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL lock_idle got=%b exp=00", grant); end
    @(negedge clk);
    for (int c = 1; c < 8; c++) begin
      req0_valid = 1; req0_last = 1;
      req1_last = (b1 == 3);
      mem_ready = c[0];
      #1;
      checks++; if (grant !== 2'b10 || req0_ready !== 1'b0 || req1_ready !== mem_ready) begin
        errors++; $display("FAIL lock_hold c=%0d grant=%b r0=%b r1=%b exp=10/0/%b", c, grant, req0_ready, req1_ready, mem_ready); end
      if (mem_ready) b1++;
      @(negedge clk);
    end
    req1_valid = 0;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL lock_release got=%b exp=00", grant); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01 || req0_ready !== 1'b0 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL lock_full_block grant=%b r0=%b mv=%b exp=01/0/0", grant, req0_ready, mem_valid); end
    mem_ready = 0;
    for (int k = 0; k < 4; k++) begin
      mem_resp_valid = 1; mem_resp_data = 64'(k);
      #1;
      checks++; if ({resp1_valid, resp0_valid} !== 2'b10) begin errors++; $display("FAIL lock_route k=%0d got=%b exp=10", k, {resp1_valid, resp0_valid}); end
      @(negedge clk);
    end
    mem_resp_valid = 0;
  endtask

  task automatic test_fifo_full();
    do_reset();
    req0_valid = 1; mem_ready = 1;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL full_idle got=%b exp=00", grant); end
    @(negedge clk);
    for (int c = 1; c < 5; c++) begin
      #1;
      checks++; if (req0_ready !== 1'b1 || mem_valid !== 1'b1) begin errors++; $display("FAIL full_accept c=%0d r0=%b mv=%b exp=1/1", c, req0_ready, mem_valid); end
      @(negedge clk);
    end
    #1;
    checks++; if (req0_ready !== 1'b0 || mem_valid !== 1'b0 || grant !== 2'b01) begin
      errors++; $display("FAIL full_block r0=%b mv=%b grant=%b exp=0/0/01", req0_ready, mem_valid, grant); end
    @(negedge clk);
    mem_resp_valid = 1;
    #1;
    checks++; if (req0_ready !== 1'b0 || resp0_valid !== 1'b1) begin
      errors++; $display("FAIL full_pop_same r0=%b resp0=%b exp=0/1", req0_ready, resp0_valid); end
    @(negedge clk);
    mem_resp_valid = 0; req0_last = 1;
    #1;
    checks++; if (req0_ready !== 1'b1 || mem_valid !== 1'b1) begin errors++; $display("FAIL full_resume r0=%b mv=%b exp=1/1", req0_ready, mem_valid); end
    @(negedge clk);
    req0_valid = 0;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL full_end got=%b exp=00", grant); end
  endtask

  task automatic test_interleave();
    logic [63:0] rd [4];
    logic        rid [4];
    rd  = '{64'h11, 64'h22, 64'h33, 64'h44};
    rid = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    mem_ready = 1; req0_write = 1; req1_write = 1;
    req0_valid = 1; req0_last = 0; req0_data = 64'hA0;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01 || mem_data !== 64'hA0 || mem_write !== 1'b1) begin
      errors++; $display("FAIL inter_b0 grant=%b data=%h wr=%b exp=01/a0/1", grant, mem_data, mem_write); end
    @(negedge clk);
    req0_last = 1; req0_data = 64'hA1;
    #1;
    checks++; if (mem_data !== 64'hA1 || mem_last !== 1'b1) begin errors++; $display("FAIL inter_b1 data=%h last=%b exp=a1/1", mem_data, mem_last); end
    @(negedge clk);
    req0_valid = 0; req1_valid = 1; req1_last = 1; req1_data = 64'hB0;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b10 || mem_data !== 64'hB0) begin errors++; $display("FAIL inter_b2 grant=%b data=%h exp=10/b0", grant, mem_data); end
    @(negedge clk);
    req1_valid = 0; req0_valid = 1; req0_data = 64'hA2;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01 || mem_data !== 64'hA2) begin errors++; $display("FAIL inter_b3 grant=%b data=%h exp=01/a2", grant, mem_data); end
    @(negedge clk);
    req0_valid = 0;
    for (int k = 0; k < 4; k++) begin
      mem_resp_valid = 1; mem_resp_data = rd[k];
      #1;
      checks++; if ({resp1_valid, resp0_valid} !== (rid[k] ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL inter_route k=%0d got=%b exp_id=%0d", k, {resp1_valid, resp0_valid}, rid[k]); end
      checks++; if ((rid[k] ? resp1_data : resp0_data) !== rd[k]) begin
        errors++; $display("FAIL inter_data k=%0d got=%h exp=%h", k, rid[k] ? resp1_data : resp0_data, rd[k]); end
      @(negedge clk);
    end
    mem_resp_valid = 0;
    #1;
    checks++; if (err_resp !== 1'b0) begin errors++; $display("FAIL inter_no_err got=%b exp=0", err_resp); end
  endtask

  task automatic test_err_sticky();
    do_reset();
    mem_resp_valid = 1; mem_resp_data = 64'h55;
    #1;
    checks++; if ({resp1_valid, resp0_valid} !== 2'b00) begin errors++; $display("FAIL err_drop got=%b exp=00", {resp1_valid, resp0_valid}); end
    @(negedge clk);
    mem_resp_valid = 0;
    #1;
    checks++; if (err_resp !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", err_resp); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (err_resp !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err_resp); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    #1;
    checks++; if (err_resp !== 1'b0) begin errors++; $display("FAIL rst_err_clear got=%b exp=0", err_resp); end
    req0_valid = 1; req0_last = 0; mem_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (grant !== 2'b01 || req0_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_busy grant=%b r0=%b exp=01/1", grant, req0_ready); end
    rst = 1;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00 || {req1_ready, req0_ready} !== 2'b00 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_clear grant=%b ready=%b mv=%b exp=00/00/0", grant, {req1_ready, req0_ready}, mem_valid); end
    rst = 0; req0_valid = 0; mem_resp_valid = 1;
    #1;
    checks++; if (resp0_valid !== 1'b0) begin errors++; $display("FAIL rst_fifo_empty resp0=%b exp=0", resp0_valid); end
    @(negedge clk);
    mem_resp_valid = 0;
    #1;
    checks++; if (err_resp !== 1'b1 || grant !== 2'b00) begin errors++; $display("FAIL rst_inflight_err err=%b grant=%b exp=1/00", err_resp, grant); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_lock_stall();
    test_fifo_full();
    test_interleave();
    test_err_sticky();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout after 200000 time units");
    $fatal(1);
  end

endmodule
